// File: rtl/spi_xip_ctrl_if.sv
// Bus bundles for the XIP controller: the upstream APB port and the
// register port of the SPI master core.

interface xip_apb_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

interface xip_reg_if;
  logic [4:0]  m_adr;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel;
  logic        m_we;
  logic        m_stb;
  logic        m_cyc;
  logic [31:0] m_dat_i;
  logic        m_ack;
  logic        m_err;
  logic        m_int;

  modport master (
    output m_adr, m_dat_o, m_sel, m_we, m_stb, m_cyc,
    input  m_dat_i, m_ack, m_err, m_int
  );

  modport slave (
    input  m_adr, m_dat_o, m_sel, m_we, m_stb, m_cyc,
    output m_dat_i, m_ack, m_err, m_int
  );
endinterface

// File: rtl/spi_xip_ctrl.sv
// APB front-end that passes register accesses through to an SPI master core
// and turns reads of the flash window into SPI read (0x03) sequences.
//
// state   | meaning
// IDLE    | waiting for an APB setup phase
// HIT     | respond from the read buffer
// WERR    | respond with error to a flash write
// PASS    | one register access forwarded to the SPI core
// DIV     | write clock divider
// SS      | write slave select
// TX      | write read command and address
// CTRL    | start the transfer
// WAIT    | wait for the transfer-done interrupt, with timeout
// RX      | read received word, respond, fill buffer

module spi_xip_ctrl #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] CLK_DIV    = 32'h1,
  parameter logic [31:0] SS_MASK    = 32'h1,
  parameter logic [31:0] CTRL_VAL   = 32'h3540,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic      clock,
  input  logic      reset,
  xip_apb_if.slave  apb,
  xip_reg_if.master spi,
  output logic      spi_irq_out
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HIT,
    ST_WERR,
    ST_PASS,
    ST_DIV,
    ST_SS,
    ST_TX,
    ST_CTRL,
    ST_WAIT,
    ST_RX
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        acc;
  logic        acc_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;

  logic [4:0]  req_adr;
  logic [21:0] req_tag;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [3:0]  req_strb;
  logic        req_load;

  logic        buf_valid;
  logic [21:0] buf_tag;
  logic [31:0] buf_data;
  logic        buf_fill;
  logic        buf_clear;

  logic        decode;
  logic        in_flash;
  logic        buf_hit;
  logic        xip_active;
  logic [31:0] rx_swap;

  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [4:0]  adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;

  assign decode   = apb.in_psel && !apb.in_penable;
  assign in_flash = (apb.in_paddr >= FLASH_BASE) && (apb.in_paddr <= FLASH_END);
  assign buf_hit  = buf_valid && (buf_tag == apb.in_paddr[23:2]);
  assign rx_swap  = {spi.m_dat_i[7:0], spi.m_dat_i[15:8],
                     spi.m_dat_i[23:16], spi.m_dat_i[31:24]};

  assign xip_active = (state == ST_DIV) || (state == ST_SS) || (state == ST_TX) ||
                      (state == ST_CTRL) || (state == ST_WAIT) || (state == ST_RX);

  // The CPU must not see the SPI-done interrupt that belongs to a flash fetch.
  assign spi_irq_out = spi.m_int && !xip_active && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      acc      <= 1'b0;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      wait_cnt <= wait_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_adr   <= 5'd0;
      req_tag   <= 22'd0;
      req_wdata <= 32'd0;
      req_write <= 1'b0;
      req_strb  <= 4'd0;
    end else if (req_load) begin
      req_adr   <= apb.in_paddr[4:0];
      req_tag   <= apb.in_paddr[23:2];
      req_wdata <= apb.in_pwdata;
      req_write <= apb.in_pwrite;
      req_strb  <= apb.in_pstrb;
    end
  end

  // A pass-through write may retarget the SPI core, so it invalidates the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= 22'd0;
      buf_data  <= 32'd0;
    end else if (buf_clear) begin
      buf_valid <= 1'b0;
    end else if (buf_fill) begin
      buf_valid <= 1'b1;
      buf_tag   <= req_tag;
      buf_data  <= rx_swap;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    wait_next  = wait_cnt;
    req_load   = 1'b0;
    buf_fill   = 1'b0;
    buf_clear  = 1'b0;
    pready     = 1'b0;
    prdata     = 32'd0;
    pslverr    = 1'b0;
    adr        = 5'd0;
    dat_o      = 32'd0;
    sel        = 4'd0;
    we         = 1'b0;
    stb        = 1'b0;
    cyc        = 1'b0;

    case (state)
      ST_IDLE: begin
        acc_next  = 1'b0;
        wait_next = 16'd0;
        if (decode) begin
          req_load = 1'b1;
          if (!in_flash)            state_next = ST_PASS;
          else if (apb.in_pwrite)   state_next = ST_WERR;
          else if (buf_hit)         state_next = ST_HIT;
          else                      state_next = ST_DIV;
        end
      end

      ST_HIT: begin
        pready     = 1'b1;
        prdata     = buf_data;
        state_next = ST_IDLE;
      end

      ST_WERR: begin
        pready     = 1'b1;
        pslverr    = 1'b1;
        state_next = ST_IDLE;
      end

      ST_WAIT: begin
        if (spi.m_int) begin
          state_next = ST_RX;
          acc_next   = 1'b0;
          wait_next  = 16'd0;
        end else if (wait_cnt == TIMEOUT - 16'd1) begin
          pready     = 1'b1;
          pslverr    = 1'b1;
          state_next = ST_IDLE;
          wait_next  = 16'd0;
        end else begin
          wait_next = wait_cnt + 16'd1;
        end
      end

      default: begin
        stb = 1'b1;
        cyc = acc;
        sel = 4'hf;
        case (state)
          ST_PASS: begin
            adr   = req_adr;
            dat_o = req_wdata;
            we    = req_write;
            sel   = req_strb;
          end
          ST_DIV:  begin adr = 5'h14; dat_o = CLK_DIV;  we = 1'b1; end
          ST_SS:   begin adr = 5'h18; dat_o = SS_MASK;  we = 1'b1; end
          ST_TX:   begin adr = 5'h04; dat_o = {8'h03, req_tag, 2'b00}; we = 1'b1; end
          ST_CTRL: begin adr = 5'h10; dat_o = CTRL_VAL; we = 1'b1; end
          default: begin adr = 5'h00; end
        endcase

        if (!acc) begin
          acc_next = 1'b1;
        end else if (spi.m_ack) begin
          acc_next = 1'b0;
          if (state == ST_PASS) begin
            pready     = 1'b1;
            prdata     = spi.m_dat_i;
            pslverr    = spi.m_err;
            buf_clear  = req_write;
            state_next = ST_IDLE;
          end else if (spi.m_err) begin
            pready     = 1'b1;
            pslverr    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            case (state)
              ST_DIV:  state_next = ST_SS;
              ST_SS:   state_next = ST_TX;
              ST_TX:   state_next = ST_CTRL;
              ST_CTRL: begin
                state_next = ST_WAIT;
                wait_next  = 16'd0;
              end
              default: begin
                pready     = 1'b1;
                prdata     = rx_swap;
                buf_fill   = 1'b1;
                state_next = ST_IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

  assign apb.in_pready  = pready;
  assign apb.in_prdata  = prdata;
  assign apb.in_pslverr = pslverr;
  assign spi.m_adr      = adr;
  assign spi.m_dat_o    = dat_o;
  assign spi.m_sel      = sel;
  assign spi.m_we       = we;
  assign spi.m_stb      = stb;
  assign spi.m_cyc      = cyc;

endmodule

// File: doc/spi_xip_ctrl.md
SPI_XIP_CTRL -- requirements
Module: spi_xip_ctrl

Interface
REQ-001 SHALL have parameter FLASH_BASE, default 32'h30000000, meaning the first byte address of the XIP flash window.
REQ-002 SHALL have parameter FLASH_END, default 32'h3fffffff, meaning the last byte address of the XIP flash window.
REQ-003 SHALL have parameter CLK_DIV, default 32'h1, meaning the value written to the SPI divider register (offset 0x14).
REQ-004 SHALL have parameter SS_MASK, default 32'h1, meaning the value written to the SPI slave-select register (offset 0x18).
REQ-005 SHALL have parameter CTRL_VAL, default 32'h3540, meaning the value written to the SPI control register (offset 0x10): GO, ASS, IE, 64-bit char.
REQ-006 SHALL have parameter TIMEOUT, default 16'd4096, meaning the maximum number of WAIT cycles before abort.
REQ-007 SHALL have ports: clock in 1 (system clock); reset in 1 (asynchronous, active-high).
REQ-008 SHALL have ports: in_paddr in 32; in_psel in 1; in_penable in 1; in_pwrite in 1; in_pwdata in 32; in_pstrb in 4 (upstream APB request).
REQ-009 SHALL have ports: in_pready out 1; in_prdata out 32; in_pslverr out 1 (upstream APB response).
REQ-010 SHALL have ports: m_adr out 5; m_dat_o out 32; m_sel out 4; m_we out 1; m_stb out 1; m_cyc out 1 (SPI master register-port request).
REQ-011 SHALL have ports: m_dat_i in 32; m_ack in 1; m_err in 1; m_int in 1 (SPI master response and interrupt).
REQ-012 SHALL have port spi_irq_out out 1 (m_int forwarded to the CPU, masked to 0 while an XIP sequence is active).

Function
REQ-013 SHALL decode a request when in_psel=1 and in_penable=0; addresses in [FLASH_BASE, FLASH_END] are flash, all others are register pass-through.
REQ-014 SHALL forward a pass-through request as one downstream access in state PASS: m_adr=in_paddr[4:0], m_dat_o=in_pwdata, m_we=in_pwrite, m_sel=in_pstrb. The upstream response SHALL carry m_dat_i and m_err unmodified, with in_pready=1 in the m_ack cycle.
REQ-015 SHALL drive each downstream access as one setup cycle (m_stb=1, m_cyc=0), then an access phase (m_stb=m_cyc=1) held until m_ack; no other downstream access SHALL start in that cycle.
REQ-016 SHALL answer a flash write with in_pready=1 and in_pslverr=1 in the cycle after setup, with no downstream activity.
REQ-017 SHALL keep a one-entry read buffer: tag = in_paddr[23:2], data, and a valid bit.
REQ-018 SHALL answer a flash read that hits the valid buffer entry with the buffered data and in_pready=1 in the cycle after setup (1-cycle latency), with no downstream activity.
REQ-019 SHALL run a flash read miss through states DIV -> SS -> TX -> CTRL -> WAIT -> RX -> IDLE. Each of DIV/SS/TX/CTRL/RX advances on m_ack of its single access.
REQ-020 SHALL use these writes for the miss sequence: DIV writes CLK_DIV to 0x14; SS writes SS_MASK to 0x18; TX writes {8'h03, in_paddr[23:2], 2'b00} to 0x04; CTRL writes CTRL_VAL to 0x10. All use m_sel=4'hf.
REQ-021 SHALL hold WAIT until m_int=1, counting cycles. If the count reaches TIMEOUT, it SHALL return in_pslverr=1 with in_pready=1, leave the buffer unchanged, and go to IDLE.
REQ-022 SHALL, in RX, read offset 0x00 and return the byte-swapped result {d[7:0],d[15:8],d[23:16],d[31:24]} on in_prdata with in_pready=1 in the m_ack cycle. In the same edge it SHALL write the swapped data and tag to the buffer and set valid.
REQ-023 SHALL abort on m_err=1 with m_ack in any miss state: in_pready=1, in_pslverr=1, buffer unchanged, next state IDLE.
REQ-024 SHALL clear buffer valid on any completed pass-through write. When a pass-through write and a buffer fill coincide, the clear SHALL take priority.
REQ-025 SHALL hold in_pready=0 at all times other than the defined response cycles; in_prdata SHALL be 0 when in_pready=0.
REQ-026 SHALL accept only one upstream transaction at a time; no request is decoded until the state returns to IDLE.

Reset
REQ-027 SHALL, while reset=1, set: state IDLE; buffer valid 0; WAIT counter 0; all outputs 0 (m_stb, m_cyc, m_we, in_pready, in_pslverr, spi_irq_out). Reset asserted mid-sequence SHALL abandon the sequence with no response.

Verification
REQ-028 SHALL be verified: flash read 0x30000104 with SPI model returning d=32'h44332211 -> writes 0x14<-1, 0x18<-1, 0x04<-0x03000104, 0x10<-0x3540; then read 0x00; in_prdata=32'h11223344.
REQ-029 SHALL be verified: repeat read 0x30000104 -> in_pready=1 one cycle after setup, data 32'h11223344, m_stb stays 0.
REQ-030 SHALL be verified: pass-through write 0x10001018 <- 0, then read 0x30000104 -> buffer miss, full 5-access sequence reissued.
REQ-031 SHALL be verified: flash write 0x30000000 -> in_pslverr=1, in_pready=1, no downstream access.
REQ-032 SHALL be verified: m_int held 0 for TIMEOUT cycles -> in_pslverr=1, then a subsequent read to the same address still misses.
REQ-033 SHALL be verified: reset pulsed in WAIT -> all outputs 0, state IDLE, next flash read misses.
